// File: rtl/tt_serial_rx_pkg.sv
// Shared constants, state encoding and status-word layout for the serial
// frame receiver tile.
package tt_serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = 3;
    localparam int FCNT_W    = 3;

    // Bit positions inside the status word shown when out_sel=1
    localparam int NEW      = 0;
    localparam int PERR     = 1;
    localparam int FERR     = 2;
    localparam int OVR      = 3;
    localparam int BUSY     = 4;
    localparam int FCNT_LSB = 5;

endpackage

// File: rtl/tt_serial_rx_shift.sv
// Receive shift register: data enters at the MSB so d0 ends up in bit 0,
// with a running XOR of every bit shifted in.
module tt_serial_rx_shift
    import tt_serial_rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift_en,
    input  logic                 din,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data   <= '0;
            parity <= 1'b0;
        end else if (load) begin
            data   <= '0;
            parity <= 1'b0;
        end else if (shift_en) begin
            data   <= {din, data[DATA_BITS-1:1]};
            parity <= parity ^ din;
        end
    end

endmodule

// File: rtl/tt_serial_frame_rx.sv
// Serial frame receiver tile: start/8-data/parity/stop at one bit per clock,
// with sticky status flags and a byte/status view on io_out.
module tt_serial_frame_rx
    import tt_serial_rx_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic clk, rst, din, parity_mode, out_sel, clr;
    assign clk         = io_in[0];
    assign rst         = io_in[1];
    assign din         = io_in[2];
    assign parity_mode = io_in[3];
    assign out_sel     = io_in[4];
    assign clr         = io_in[5];

    logic unused_io;
    assign unused_io = &{1'b0, io_in[7:6]};

    rx_state_t              state, state_next;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   perr_pend;
    logic [DATA_BITS-1:0]   data_reg;
    logic [FCNT_W-1:0]      frame_cnt;
    logic                   flag_new, perr, ferr, ovr;

    logic [DATA_BITS-1:0]   shift_data;
    logic                   shift_parity;

    logic load, shift_en, busy;
    logic commit_good, set_perr, set_ferr;
    logic last_bit;

    assign last_bit = (bit_cnt == BIT_CNT_W'(DATA_BITS - 1));

    tt_serial_rx_shift u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .din      (din),
        .data     (shift_data),
        .parity   (shift_parity)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!din) state_next = DATA;
            DATA:    if (last_bit) state_next = PARITY;
            PARITY:  state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load        = (state == IDLE) && !din;
        shift_en    = (state == DATA);
        busy        = (state != IDLE);
        commit_good = (state == STOP) && din && !perr_pend;
        set_perr    = (state == STOP) && perr_pend;
        set_ferr    = (state == STOP) && !din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            perr_pend <= 1'b0;
            data_reg  <= '0;
            frame_cnt <= '0;
        end else begin
            if (load)
                bit_cnt <= '0;
            else if (shift_en && !last_bit)
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (state == PARITY)
                perr_pend <= shift_parity ^ din ^ parity_mode;
            if (commit_good) begin
                data_reg  <= shift_data;
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

    // Sticky flags: a set event on the same edge as clr takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_new <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (commit_good)   flag_new <= 1'b1;
            else if (clr)      flag_new <= 1'b0;
            if (set_perr)      perr <= 1'b1;
            else if (clr)      perr <= 1'b0;
            if (set_ferr)      ferr <= 1'b1;
            else if (clr)      ferr <= 1'b0;
            if (commit_good && flag_new) ovr <= 1'b1;
            else if (clr)      ovr <= 1'b0;
        end
    end

    logic [7:0] status;
    always_comb begin
        status                      = '0;
        status[NEW]                 = flag_new;
        status[PERR]                = perr;
        status[FERR]                = ferr;
        status[OVR]                 = ovr;
        status[BUSY]                = busy;
        status[FCNT_LSB +: FCNT_W]  = frame_cnt;
    end

    assign io_out = out_sel ? status : data_reg;

endmodule

// File: tb/tb_tt_serial_frame_rx.sv
// Directed self-checking bench for the serial frame receiver tile.
module tb_tt_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       parity_mode = 1'b0;
    logic       out_sel = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int checks = 0;
    int failures = 0;

    assign io_in = {2'b00, clr, out_sel, parity_mode, din, rst, clk};

    tt_serial_frame_rx dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
        end
    endtask

    task automatic checkView(input string tag, input logic sel, input logic [7:0] expected);
        out_sel = sel;
        #1;
        checkOutput(tag, io_out, expected);
    endtask

    // Drive one bit now (at a falling edge) and return at the next falling edge
    task automatic applyStimulus(input logic b);
        din = b;
        @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic par, input logic stop, input logic clr_on_stop);
        applyStimulus(1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(data[i]);
        applyStimulus(par);
        clr = clr_on_stop;
        applyStimulus(stop);
        clr = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        din = 1'b1;
        clr = 1'b0;
        parity_mode = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1);
    endtask

    initial begin
        logic [7:0] b;
        @(negedge clk);
        resetDut();

        // Reset mid-frame wipes a previously committed byte and the partial frame
        sendFrame(8'hA5, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(i[0] ? 1'b0 : 1'b1);
        checkView("busy_mid_frame", 1'b1, 8'h31);
        rst = 1'b1;
        applyStimulus(1'b1);
        rst = 1'b0;
        applyStimulus(1'b1);
        checkView("reset_data", 1'b0, 8'h00);
        checkView("reset_status", 1'b1, 8'h00);

        // Good frame, even parity
        resetDut();
        sendFrame(8'hA5, 1'b0, 1'b1, 1'b0);
        checkView("good_data", 1'b0, 8'hA5);
        checkView("good_status", 1'b1, 8'h21);

        // Parity error from reset
        resetDut();
        sendFrame(8'hA5, 1'b1, 1'b1, 1'b0);
        checkView("perr_data", 1'b0, 8'h00);
        checkView("perr_status", 1'b1, 8'h02);

        // Parity error after a good frame keeps data and count
        resetDut();
        sendFrame(8'hA5, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h5A, 1'b1, 1'b1, 1'b0);
        checkView("perr_hold_data", 1'b0, 8'hA5);
        checkView("perr_hold_status", 1'b1, 8'h23);

        // Framing error in odd mode, line held low re-triggers, then clr
        resetDut();
        parity_mode = 1'b1;
        sendFrame(8'h3C, 1'b1, 1'b0, 1'b0);
        checkView("ferr_status", 1'b1, 8'h04);
        applyStimulus(1'b0);
        checkView("ferr_retrigger_busy", 1'b1, 8'h14);
        clr = 1'b1;
        applyStimulus(1'b1);
        clr = 1'b0;
        checkView("ferr_after_clr", 1'b1, 8'h10);

        // Overrun: two back-to-back good frames without clr
        resetDut();
        sendFrame(8'h11, 1'b0, 1'b1, 1'b0);
        checkView("first_of_pair", 1'b1, 8'h21);
        sendFrame(8'h22, 1'b0, 1'b1, 1'b0);
        checkView("ovr_data", 1'b0, 8'h22);
        checkView("ovr_status", 1'b1, 8'h49);

        // Eight good frames wrap the frame counter to zero
        resetDut();
        for (int i = 0; i < 8; i++) begin
            b = 8'(i * 17 + 3);
            sendFrame(b, ^b, 1'b1, 1'b0);
        end
        checkView("wrap_data", 1'b0, 8'h7A);
        checkView("wrap_status", 1'b1, 8'h09);

        // clr on the stop edge: new is set, older perr is cleared
        resetDut();
        sendFrame(8'hA5, 1'b1, 1'b1, 1'b0);
        sendFrame(8'h3C, 1'b0, 1'b1, 1'b1);
        checkView("clr_vs_set_data", 1'b0, 8'h3C);
        checkView("clr_vs_set_status", 1'b1, 8'h21);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
